// File: rtl/wb_master_seq.sv
// wb_master_seq: single-outstanding Wishbone classic master driven by a cmd/rsp handshake; WBM_TIMEOUT_EN adds an ack timeout
module wb_master_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ADDR_LIMIT     = 32'h0000_2000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t      r_state, w_next;
  logic        r_rdy, r_cyc, r_we, r_rv, r_err;
  logic [31:0] r_adr, r_dat, r_rdat;
  logic [3:0]  r_sel;
  logic        w_acc, w_legal, w_exp;
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_master_seq: TIMEOUT_CYCLES must be 1..65535");
  end
  assign w_acc   = cmd_valid && r_rdy;
  assign w_legal = (cmd_adr < ADDR_LIMIT) && (cmd_sel != 4'd0);
`ifdef WBM_TIMEOUT_EN
  logic [15:0] r_cnt;
  // expiry is flagged on the last allowed BUS cycle so cyc/stb stay up exactly TIMEOUT_CYCLES cycles
  assign w_exp = (r_state == BUS) && !wbm_ack_i && (r_cnt == 16'(TIMEOUT_CYCLES - 1));
  // cycle counter: held at zero outside BUS, counts every BUS cycle
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) r_cnt <= '0;
    else r_cnt <= (r_state == BUS) ? r_cnt + 16'd1 : 16'd0;
  end
`else
  assign w_exp = 1'b0;
`endif
  // state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next state; ack in the expiry cycle wins because it is tested first in the datapath
  always_comb begin
    w_next = (r_state == IDLE) ? (w_acc ? (w_legal ? BUS : RESP) : IDLE) :
             (r_state == BUS)  ? ((wbm_ack_i || w_exp) ? RESP : BUS) :
             (rsp_ready ? IDLE : RESP);
  end
  // registered bus controls and response; cmd_ready is registered so it stays low during reset
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_rdy  <= 1'b0;
      r_cyc  <= 1'b0;
      r_we   <= 1'b0;
      r_adr  <= '0;
      r_dat  <= '0;
      r_sel  <= '0;
      r_rv   <= 1'b0;
      r_err  <= 1'b0;
      r_rdat <= '0;
    end else begin
      r_rdy <= (w_next == IDLE);
      if (r_state == IDLE && w_acc) begin
        r_cyc  <= w_legal;
        r_we   <= w_legal && cmd_we;
        r_adr  <= w_legal ? {cmd_adr[31:2], 2'b00} : '0;
        r_dat  <= w_legal ? cmd_dat : '0;
        r_sel  <= w_legal ? cmd_sel : '0;
        r_rv   <= !w_legal;
        r_err  <= !w_legal;
        r_rdat <= '0;
      end else if (r_state == BUS && w_next == RESP) begin
        r_cyc  <= 1'b0;
        r_we   <= 1'b0;
        r_adr  <= '0;
        r_dat  <= '0;
        r_sel  <= '0;
        r_rv   <= 1'b1;
        r_err  <= !wbm_ack_i;
        r_rdat <= (wbm_ack_i && !r_we) ? wbm_dat_i : '0;
      end else if (r_state == RESP && rsp_ready) begin
        r_rv   <= 1'b0;
        r_err  <= 1'b0;
        r_rdat <= '0;
      end
    end
  end
  assign cmd_ready = r_rdy;
  assign busy      = (r_state != IDLE);
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_we_o  = r_we;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign wbm_sel_o = r_sel;
  assign rsp_valid = r_rv;
  assign rsp_err   = r_err;
  assign rsp_dat   = r_rdat;
endmodule

// File: tb/tb_wb_master_seq.sv
// tb_wb_master_seq: directed vector table plus hand sequences for wb_master_seq
module tb_wb_master_seq;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid = 0, cmd_ready, cmd_we = 0;
  logic [31:0] cmd_adr = 0, cmd_dat = 0;
  logic [3:0]  cmd_sel = 0;
  logic        rsp_valid, rsp_ready = 0, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i = 0;
  logic        wbm_ack_i = 0, busy;
  int n_tests = 0, n_fail = 0;

  wb_master_seq #(.TIMEOUT_CYCLES(8), .ADDR_LIMIT(32'h0000_2000)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic v, we; logic [31:0] adr, dat; logic [3:0] sel; logic ack; logic [31:0] di; logic rr;
    logic e_rdy, e_cyc, e_we; logic [31:0] e_adr, e_dat; logic [3:0] e_sel;
    logic e_rv, e_err; logic [31:0] e_rdat;
  } vec_t;
  vec_t tv[$];

  task automatic add(input logic v, we, input logic [31:0] adr, dat, input logic [3:0] sel,
                     input logic ack, input logic [31:0] di, input logic rr,
                     input logic e_rdy, e_cyc, e_we, input logic [31:0] e_adr, e_dat,
                     input logic [3:0] e_sel, input logic e_rv, e_err, input logic [31:0] e_rdat);
    vec_t t;
    t.v = v; t.we = we; t.adr = adr; t.dat = dat; t.sel = sel; t.ack = ack; t.di = di; t.rr = rr;
    t.e_rdy = e_rdy; t.e_cyc = e_cyc; t.e_we = e_we; t.e_adr = e_adr; t.e_dat = e_dat;
    t.e_sel = e_sel; t.e_rv = e_rv; t.e_err = e_err; t.e_rdat = e_rdat;
    tv.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command from IDLE; slave acks on BUS cycle dly+1 (never if dly < 0).
  // Returns with the DUT out of BUS (or after 40 BUS cycles) and rsp_ready low.
  task automatic do_cmd(input logic we, input logic [31:0] adr, dat, input logic [3:0] sel,
                        input int dly, input logic [31:0] di, output int ncyc);
    cmd_valid = 1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; rsp_ready = 0;
    step();
    cmd_valid = 0;
    ncyc = 0;
    for (int i = 0; i < 40 && wbm_cyc_o; i++) begin
      ncyc++;
      chk("bus_hold", {wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o},
          {1'b1, we, adr & 32'hFFFF_FFFC, dat, sel});
      wbm_ack_i = (ncyc == dly + 1);
      wbm_dat_i = di;
      step();
    end
    wbm_ack_i = 0;
  endtask

  task automatic release_rsp();
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("rsp_release", {cmd_ready, busy, rsp_valid}, 3'b100);
  endtask

  int n, k_acc, k_rsp, bc;
  logic acc;
  logic [31:0] exp_d;

  initial begin
    // reset: everything low before any clock edge, cmd_ready after the first edge
    #3;
    chk("reset_async", {cmd_ready, busy, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
                        wbm_sel_o, rsp_valid, rsp_err, rsp_dat}, '0);
    repeat (2) @(posedge clk);
    #4 rst_n = 1;
    step();
    chk("reset_release", {cmd_ready, busy, wbm_cyc_o, rsp_valid}, 4'b1000);

    //   v we adr            dat            sel   ack di             rr | rdy cyc we e_adr          e_dat          e_sel rv err rdat
    add(1, 0, 32'h0000_0010, 32'h0,         4'hF, 0, 32'h0,         0,  0,  1,  0, 32'h0000_0010, 32'h0,         4'hF, 0, 0, 32'h0);
    add(0, 0, 32'h0,         32'h0,         4'h0, 1, 32'hDEAD_BEEF, 0,  0,  0,  0, 32'h0,         32'h0,         4'h0, 1, 0, 32'hDEAD_BEEF);
    add(0, 0, 32'h0,         32'h0,         4'h0, 0, 32'h0,         1,  1,  0,  0, 32'h0,         32'h0,         4'h0, 0, 0, 32'h0);
    add(1, 0, 32'h0000_2000, 32'h0,         4'hF, 0, 32'h0,         0,  0,  0,  0, 32'h0,         32'h0,         4'h0, 1, 1, 32'h0);
    add(0, 0, 32'h0,         32'h0,         4'h0, 0, 32'h0,         1,  1,  0,  0, 32'h0,         32'h0,         4'h0, 0, 0, 32'h0);
    add(1, 1, 32'hFFFF_FFFC, 32'h1,         4'hF, 0, 32'h0,         0,  0,  0,  0, 32'h0,         32'h0,         4'h0, 1, 1, 32'h0);
    add(0, 0, 32'h0,         32'h0,         4'h0, 0, 32'h0,         1,  1,  0,  0, 32'h0,         32'h0,         4'h0, 0, 0, 32'h0);
    add(1, 0, 32'h0000_1003, 32'h0,         4'h0, 0, 32'h0,         0,  0,  0,  0, 32'h0,         32'h0,         4'h0, 1, 1, 32'h0);
    add(0, 0, 32'h0,         32'h0,         4'h0, 0, 32'h0,         1,  1,  0,  0, 32'h0,         32'h0,         4'h0, 0, 0, 32'h0);
    add(1, 1, 32'h0000_1FFF, 32'h1122_3344, 4'h3, 0, 32'h0,         0,  0,  1,  1, 32'h0000_1FFC, 32'h1122_3344, 4'h3, 0, 0, 32'h0);
    add(0, 0, 32'h0,         32'h0,         4'h0, 1, 32'hFFFF_FFFF, 0,  0,  0,  0, 32'h0,         32'h0,         4'h0, 1, 0, 32'h0);
    add(0, 0, 32'h0,         32'h0,         4'h0, 0, 32'h0,         1,  1,  0,  0, 32'h0,         32'h0,         4'h0, 0, 0, 32'h0);
    add(0, 0, 32'h0,         32'h0,         4'h0, 1, 32'h5555_5555, 0,  1,  0,  0, 32'h0,         32'h0,         4'h0, 0, 0, 32'h0);
    foreach (tv[i]) begin
      cmd_valid = tv[i].v; cmd_we = tv[i].we; cmd_adr = tv[i].adr; cmd_dat = tv[i].dat;
      cmd_sel = tv[i].sel; wbm_ack_i = tv[i].ack; wbm_dat_i = tv[i].di; rsp_ready = tv[i].rr;
      step();
      chk($sformatf("vec%0d_ctl", i), {cmd_ready, busy, wbm_cyc_o, wbm_stb_o, rsp_valid, rsp_err, rsp_dat},
          {tv[i].e_rdy, !tv[i].e_rdy, tv[i].e_cyc, tv[i].e_cyc, tv[i].e_rv, tv[i].e_err, tv[i].e_rdat});
      if (tv[i].e_cyc)
        chk($sformatf("vec%0d_bus", i), {wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o},
            {tv[i].e_we, tv[i].e_adr, tv[i].e_dat, tv[i].e_sel});
    end
    cmd_valid = 0; wbm_ack_i = 0; rsp_ready = 0;

    // write with ack on the third BUS cycle
    do_cmd(1, 32'h0000_1004, 32'hA5A5_5A5A, 4'hF, 2, 32'hFFFF_0000, n);
    chk("wr_cyc_len", n, 3);
    chk("wr_rsp", {rsp_valid, rsp_err, rsp_dat}, {1'b1, 1'b0, 32'h0});
    release_rsp();

    // read with minimum turnaround, response held five cycles while a new command is offered
    do_cmd(0, 32'h0000_0010, 32'h0, 4'hF, 0, 32'h1234_5678, n);
    chk("rd_cyc_len", n, 1);
    cmd_valid = 1; cmd_adr = 32'h0000_0100; cmd_sel = 4'hF;
    for (int i = 0; i < 5; i++) begin
      chk("rd_hold", {cmd_ready, busy, wbm_cyc_o, rsp_valid, rsp_err, rsp_dat},
          {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1234_5678});
      step();
    end
    cmd_valid = 0;
    release_rsp();

`ifdef WBM_TIMEOUT_EN
    // slave never acks: cyc/stb high for exactly TIMEOUT_CYCLES
    do_cmd(0, 32'h0000_0200, 32'h0, 4'hF, -1, 32'h7777_7777, n);
    chk("to_cyc_len", n, 8);
    chk("to_rsp", {wbm_cyc_o, rsp_valid, rsp_err, rsp_dat}, {1'b0, 1'b1, 1'b1, 32'h0});
    release_rsp();
    // ack in the expiry cycle wins
    do_cmd(0, 32'h0000_0204, 32'h0, 4'hF, 7, 32'hCAFE_F00D, n);
    chk("to_ack_len", n, 8);
    chk("to_ack_rsp", {rsp_valid, rsp_err, rsp_dat}, {1'b1, 1'b0, 32'hCAFE_F00D});
    release_rsp();
`else
    // without the timeout the bus waits for ack indefinitely
    do_cmd(0, 32'h0000_0200, 32'h0, 4'hF, -1, 32'h7777_7777, n);
    chk("nto_wait", {n, wbm_cyc_o, rsp_valid}, {32'd40, 1'b1, 1'b0});
    wbm_ack_i = 1; wbm_dat_i = 32'h55AA_55AA;
    step();
    wbm_ack_i = 0;
    chk("nto_rsp", {wbm_cyc_o, rsp_valid, rsp_err, rsp_dat}, {1'b0, 1'b1, 1'b0, 32'h55AA_55AA});
    release_rsp();
`endif

    // reset in the middle of a bus cycle
    cmd_valid = 1; cmd_we = 0; cmd_adr = 32'h0000_0040; cmd_sel = 4'hF; rsp_ready = 0;
    step();
    cmd_valid = 0;
    chk("mid_pre", {wbm_cyc_o, busy}, 2'b11);
    #2 rst_n = 0;
    #1;
    chk("mid_async", {cmd_ready, busy, wbm_cyc_o, wbm_stb_o, rsp_valid, rsp_err}, 6'b0);
    repeat (2) @(posedge clk);
    #4 rst_n = 1;
    step();
    chk("mid_release", {cmd_ready, busy, wbm_cyc_o, rsp_valid}, 4'b1000);
    step();
    chk("mid_no_rsp", {rsp_valid, wbm_cyc_o}, 2'b00);
    do_cmd(0, 32'h0000_0000, 32'h0, 4'hF, 1, 32'h0BAD_CAFE, n);
    chk("mid_rd_len", n, 2);
    chk("mid_rd_rsp", {rsp_valid, rsp_err, rsp_dat}, {1'b1, 1'b0, 32'h0BAD_CAFE});
    release_rsp();

    // back-to-back reads, cmd_valid held, rsp_ready held, ack on the second BUS cycle
    k_acc = 0; k_rsp = 0; bc = 0;
    cmd_valid = 1; cmd_we = 0; cmd_adr = 32'h0000_0020; cmd_sel = 4'hF; rsp_ready = 1;
    for (int i = 0; i < 60 && k_rsp < 3; i++) begin
      if (rsp_valid) begin
        exp_d = {16'h0020 + 16'(4 * k_rsp), 16'hBEEF};
        chk($sformatf("b2b_rsp%0d", k_rsp), {rsp_err, rsp_dat}, {1'b0, exp_d});
        k_rsp++;
      end
      chk("b2b_no_overlap", rsp_valid && wbm_cyc_o, 1'b0);
      acc = cmd_valid && cmd_ready;
      bc = wbm_cyc_o ? bc + 1 : 0;
      wbm_ack_i = wbm_cyc_o && (bc == 2);
      wbm_dat_i = {wbm_adr_o[15:0], 16'hBEEF};
      step();
      if (acc) begin
        k_acc++;
        cmd_adr = 32'h0000_0020 + 32'(4 * k_acc);
        if (k_acc == 3) cmd_valid = 0;
      end
    end
    wbm_ack_i = 0; rsp_ready = 0; cmd_valid = 0;
    chk("b2b_count", {k_acc, k_rsp}, {32'd3, 32'd3});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_master_seq.md
WB_MASTER_SEQ -- requirements
Module: wb_master_seq

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max bus cycles to wait for ack (1..65535).
REQ-002 Parameter: ADDR_LIMIT, default 32'h0000_2000, exclusive upper bound of the legal target address window (covers both 4 KB slave windows).
REQ-003 wb_clk_i  in  1  sole clock, rising edge.
REQ-004 wb_rst_n_i  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  command can be accepted.
REQ-007 cmd_we  in  1  1 = write, 0 = read.
REQ-008 cmd_adr  in  32  byte address.
REQ-009 cmd_dat  in  32  write data.
REQ-010 cmd_sel  in  4  byte enables.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  response consumed.
REQ-013 rsp_dat  out  32  read data (0 for writes/errors).
REQ-014 rsp_err  out  1  1 = illegal address, zero sel, or timeout.
REQ-015 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone classic master controls.
REQ-016 wbm_adr_o  out  32, wbm_dat_o  out  32, wbm_sel_o  out  4  Wishbone address/data/select.
REQ-017 wbm_dat_i  in  32, wbm_ack_i  in  1  slave return path.
REQ-018 busy  out  1  high whenever state is not IDLE.

Function
REQ-019 FSM states: IDLE, BUS, RESP; all Wishbone outputs registered.
REQ-020 cmd_ready SHALL equal (state == IDLE); a command is accepted on cycle N when cmd_valid && cmd_ready.
REQ-021 Legal command (cmd_adr < ADDR_LIMIT and cmd_sel != 0): enter BUS at N+1 with wbm_cyc_o = wbm_stb_o = 1, wbm_we_o/wbm_dat_o/wbm_sel_o from the command, wbm_adr_o = {cmd_adr[31:2], 2'b00}.
REQ-022 Illegal command: no bus cycle; enter RESP at N+1 with rsp_err = 1, rsp_dat = 0.
REQ-023 In BUS, on the first cycle wbm_ack_i is sampled high: capture wbm_dat_i into rsp_dat (reads) or 0 (writes), rsp_err = 0, deassert cyc/stb and enter RESP on the next edge; rsp_valid high from that edge.
REQ-024 All Wishbone outputs SHALL stay stable while in BUS; wbm_ack_i is ignored outside BUS.
REQ-025 In RESP, rsp_valid = 1 with rsp_dat/rsp_err stable until rsp_valid && rsp_ready; then IDLE on the next edge; no new command is accepted in RESP (no overlap).
REQ-026 Minimum turnaround: accept N, ack at N+1, rsp_valid at N+2, rsp_ready at N+2, cmd_ready again at N+3.
REQ-027 wbm_cyc_o and wbm_stb_o are always equal; both are 0 outside BUS.

Reset
REQ-028 While wb_rst_n_i = 0 (asynchronously, including mid-BUS): state = IDLE, all outputs 0 (cmd_ready = 0, cyc/stb dropped immediately), timeout counter 0.
REQ-029 First edge after release: cmd_ready = 1; no response is produced for a transaction aborted by reset.

Configuration
REQ-030 Macro WBM_TIMEOUT_EN defined: a 16-bit counter, cleared on BUS entry, increments each BUS cycle without ack; when it reaches TIMEOUT_CYCLES without ack, drop cyc/stb and enter RESP with rsp_err = 1, rsp_dat = 0; ack in the same cycle as expiry wins (normal response).
REQ-031 WBM_TIMEOUT_EN undefined: no counter is implemented; BUS waits for ack indefinitely; TIMEOUT_CYCLES is unused.

Verification
REQ-032 Write: cmd adr 0x0000_1004, dat 0xA5A5_5A5A, sel 0xF, slave ack after 2 cycles -> one cyc/stb pulse of 3 cycles with we = 1, rsp_valid with rsp_err = 0, rsp_dat = 0.
REQ-033 Read: adr 0x0000_0010, slave returns 0x1234_5678 with ack -> rsp_dat = 0x1234_5678, rsp_err = 0; rsp held 5 cycles with rsp_ready = 0, stable throughout.
REQ-034 Illegal: adr 0x0000_2000, and separately sel 0x0 -> cyc never asserted, rsp_valid at N+1 with rsp_err = 1.
REQ-035 Timeout (macro on, TIMEOUT_CYCLES = 8, slave never acks) -> cyc/stb high exactly 8 cycles, then rsp_err = 1; ack on cycle 8 -> rsp_err = 0.
REQ-036 Reset asserted mid-BUS -> cyc/stb drop without a clock edge, rsp_valid stays 0; after release, a read to 0x0000_0000 completes normally.
REQ-037 Back-to-back: cmd_valid held high for 3 commands with rsp_ready = 1 and ack after 1 cycle -> 3 responses in order, no overlapping bus cycles.
